// File: rtl/toi2s_pkg.sv
// Shared S/PDIF framing constants, preamble codes and helpers.
// No logic of its own; no latency.
// No handshake of its own; no backpressure.
package toi2s_pkg;

    localparam logic [7:0] SPDIF_PRE_B = 8'b1110_1000;
    localparam logic [7:0] SPDIF_PRE_M = 8'b1110_0010;
    localparam logic [7:0] SPDIF_PRE_W = 8'b1110_0100;

    localparam int SPDIF_FRAMES = 192;
    localparam int SPDIF_SLOTS  = 32;

    localparam logic [4:0] AUDIO_LSB = 5'd4;
    localparam logic [4:0] SLOT_V    = 5'd28;
    localparam logic [4:0] SLOT_U    = 5'd29;
    localparam logic [4:0] SLOT_C    = 5'd30;
    localparam logic [4:0] SLOT_P    = 5'd31;

    typedef enum logic [1:0] {PRE_B, PRE_M, PRE_W} spdif_pre_t;

    // Preamble code as sent when the line was low before slot 0.
    function automatic logic [7:0] pre_pattern(input spdif_pre_t p);
        case (p)
            PRE_B:   return SPDIF_PRE_B;
            PRE_M:   return SPDIF_PRE_M;
            default: return SPDIF_PRE_W;
        endcase
    endfunction

endpackage

// File: rtl/spdif_tx_bmc.sv
// UI divider plus biphase-mark / preamble serializer for one UI at a time.
// Line output registered; updates on the clock edge ending each UI tick.
// No backpressure: the caller presents slot position and bit every tick.
module spdif_tx_bmc
    import toi2s_pkg::*;
#(
    parameter int UI_DIV = 4,
    parameter int CNT_W  = 3
) (
    input  logic       clk,
    input  logic       resetb,
    input  logic       ena,
    input  logic [4:0] slot,
    input  logic       half,
    input  spdif_pre_t pre,
    input  logic       slot_bit,
    output logic       tick,
    output logic       line
);

    logic [CNT_W-1:0] ui_cnt;
    logic             en_q;
    logic             pre_inv;
    logic [2:0]       pre_idx;
    logic [7:0]       pat;
    logic             pre_lvl;
    logic             line_nxt;
    logic             in_pre;

    // en_q keeps tick low while reset is held, even when UI_DIV is 1.
    assign tick    = en_q && ena && (ui_cnt == CNT_W'(UI_DIV - 1));
    assign pre_idx = {slot[1:0], half};
    assign in_pre  = (slot < AUDIO_LSB);
    assign pat     = pre_pattern(pre);

    always_comb begin
        pre_lvl  = (pre_idx == 3'd0) ? line : pre_inv;
        line_nxt = line;
        if (in_pre)
            line_nxt = pat[3'd7 - pre_idx] ^ pre_lvl;
        else if (!half)
            line_nxt = ~line;
        else
            line_nxt = line ^ slot_bit;
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            ui_cnt  <= '0;
            en_q    <= 1'b0;
            line    <= 1'b0;
            pre_inv <= 1'b0;
        end else if (!ena) begin
            ui_cnt  <= '0;
            en_q    <= 1'b0;
            line    <= 1'b0;
            pre_inv <= 1'b0;
        end else begin
            en_q <= 1'b1;
            if (en_q)
                ui_cnt <= tick ? '0 : ui_cnt + CNT_W'(1);
            if (tick) begin
                line <= line_nxt;
                if (in_pre && pre_idx == 3'd0)
                    pre_inv <= line;
            end
        end
    end

endmodule

// File: rtl/spdif_tx.sv
// S/PDIF consumer transmitter: 24-bit L/R pairs in, BMC stream out in 192-frame blocks.
// Sample captured on the frame-start UI tick; left audio leaves 8 UI later, right 64 UI after left.
// sample_ready pulses once per frame; a missing sample is replaced by zero with V=1 and an underrun pulse.
module spdif_tx
    import toi2s_pkg::*;
#(
    parameter int UI_DIV = 4,
    parameter int CNT_W  = 3
) (
    input  logic        clk,
    input  logic        resetb,
    input  logic        ena,
    input  logic [23:0] sample_l,
    input  logic [23:0] sample_r,
    input  logic        sample_valid,
    output logic        sample_ready,
    input  logic [31:0] cs_bits,
    output logic        spdif_out,
    output logic        underrun,
    output logic        block_start
);

    localparam logic [7:0] FRAME_LAST = 8'(SPDIF_FRAMES - 1);
    localparam logic [4:0] SLOT_LAST  = 5'(SPDIF_SLOTS - 1);

    logic        tick;
    logic        half;
    logic        sub;
    logic [4:0]  slot;
    logic [7:0]  frame_cnt;
    logic [23:0] hold_l;
    logic [23:0] hold_r;
    logic        v_flag;
    logic [31:0] cs_reg;
    logic [23:0] data;
    logic [4:0]  aud_idx;
    logic        frame_start;
    logic        c_bit;
    logic        par;
    logic        slot_bit;
    spdif_pre_t  pre;

    assign frame_start  = tick && (slot == 5'd0) && !half && !sub;
    assign sample_ready = frame_start;
    assign underrun     = frame_start && !sample_valid;
    assign block_start  = frame_start && (frame_cnt == 8'd0);

    assign data    = sub ? hold_r : hold_l;
    assign aud_idx = slot - AUDIO_LSB;
    assign c_bit   = (frame_cnt < 8'd32) && cs_reg[frame_cnt[4:0]];
    // Even parity over audio, V, U (always 0) and C.
    assign par     = ^{data, v_flag, c_bit};

    always_comb begin
        case (slot)
            SLOT_V:  slot_bit = v_flag;
            SLOT_U:  slot_bit = 1'b0;
            SLOT_C:  slot_bit = c_bit;
            SLOT_P:  slot_bit = par;
            default: slot_bit = data[aud_idx];
        endcase
        if (sub)
            pre = PRE_W;
        else if (frame_cnt == 8'd0)
            pre = PRE_B;
        else
            pre = PRE_M;
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            half      <= 1'b0;
            slot      <= '0;
            sub       <= 1'b0;
            frame_cnt <= '0;
            hold_l    <= '0;
            hold_r    <= '0;
            v_flag    <= 1'b0;
            cs_reg    <= '0;
        end else if (!ena) begin
            half      <= 1'b0;
            slot      <= '0;
            sub       <= 1'b0;
            frame_cnt <= '0;
            hold_l    <= '0;
            hold_r    <= '0;
            v_flag    <= 1'b0;
            cs_reg    <= '0;
        end else if (tick) begin
            half <= ~half;
            if (half) begin
                slot <= slot + 5'd1;
                if (slot == SLOT_LAST) begin
                    sub <= ~sub;
                    if (sub)
                        frame_cnt <= (frame_cnt == FRAME_LAST) ? 8'd0 : frame_cnt + 8'd1;
                end
            end
            if (frame_start) begin
                hold_l <= sample_valid ? sample_l : '0;
                hold_r <= sample_valid ? sample_r : '0;
                v_flag <= !sample_valid;
                if (frame_cnt == 8'd0)
                    cs_reg <= cs_bits;
            end
        end
    end

    spdif_tx_bmc #(
        .UI_DIV (UI_DIV),
        .CNT_W  (CNT_W)
    ) u_bmc (
        .clk      (clk),
        .resetb   (resetb),
        .ena      (ena),
        .slot     (slot),
        .half     (half),
        .pre      (pre),
        .slot_bit (slot_bit),
        .tick     (tick),
        .line     (spdif_out)
    );

endmodule
